ioport_ctrl: RTL and testbench

CPU-facing controller for one 8-bit bidirectional ioport instance on the j1a/iCE40 platform. It holds the output and direction shadow registers and sequences the port's registered-output write enable. It also synchronises and debounces the port's input bits, and latches per-pin change events into a sticky, maskable interrupt. It sits between the j1a IO decode and the ioport pad wrapper.

---
 rtl/ioport_pkg.sv | 18 +
 rtl/io_debounce.sv | 58 +++++
 rtl/ioport_ctrl.sv | 118 +++++++++++
 tb/tb_ioport_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ioport_pkg.sv
// Shared definitions for the ioport controller: register map and counter sizing.
package ioport_pkg;

  localparam logic [2:0] ADDR_OUT = 3'd0;
  localparam logic [2:0] ADDR_DIR = 3'd1;
  localparam logic [2:0] ADDR_SET = 3'd2;
  localparam logic [2:0] ADDR_CLR = 3'd3;
  localparam logic [2:0] ADDR_TGL = 3'd4;
  localparam logic [2:0] ADDR_IN  = 3'd5;
  localparam logic [2:0] ADDR_EVT = 3'd6;
  localparam logic [2:0] ADDR_IEN = 3'd7;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-pin debouncer: db follows sync only after DB_CNT consecutive differing ticks.
module io_debounce #(
  parameter int DB_CNT = 3,
  parameter int CW     = 2
) (
  input  logic clk,
  input  logic resetq,
  input  logic tick_i,
  input  logic armed_i,
  input  logic sync_i,
  output logic db_o,
  output logic chg_o
);

  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hit_s;

  assign hit_s = (cnt_q == CW'(DB_CNT - 1));

  // The first tick only captures the pin; chg pulses in the same cycle db flips.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    chg_o = 1'b0;
    if (tick_i) begin
      if (!armed_i) begin
        db_d  = sync_i;
        cnt_d = {CW{1'b0}};
      end else if (sync_i == db_q) begin
        cnt_d = {CW{1'b0}};
      end else if (hit_s) begin
        db_d  = sync_i;
        cnt_d = {CW{1'b0}};
        chg_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      db_q  <= 1'b0;
      cnt_q <= {CW{1'b0}};
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/ioport_ctrl.sv
// CPU-side controller for one 8-bit ioport: shadow registers, port_we sequencing,
// synchronised/debounced inputs and a sticky maskable change interrupt.
module ioport_ctrl
  import ioport_pkg::*;
#(
  parameter int DB_DIV = 1000,
  parameter int DB_CNT = 3
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       bus_we,
  input  logic       bus_re,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_wd,
  output logic [7:0] bus_rd,
  output logic       port_we,
  output logic [7:0] port_wd,
  output logic [7:0] port_dir,
  input  logic [7:0] port_rd,
  output logic       irq
);

  localparam int PW = cnt_w(DB_DIV);
  localparam int CW = cnt_w(DB_CNT + 1);

  logic [7:0]    out_q, out_d, dir_q, dir_d, ien_q, ien_d, evt_q, evt_d;
  logic [7:0]    rd_q, rd_mux_s, evt_clr_s;
  logic [7:0]    sync1_q, sync2_q, db_s, chg_s;
  logic [PW-1:0] presc_q;
  logic          port_we_q, init_q, irq_q, armed_q, out_wr_s, tick_s;

  assign tick_s = (presc_q == PW'(DB_DIV - 1));

  for (genvar i = 0; i < 8; i++) begin : g_db
    io_debounce #(.DB_CNT(DB_CNT), .CW(CW)) u_db (
      .clk     (clk),
      .resetq  (resetq),
      .tick_i  (tick_s),
      .armed_i (armed_q),
      .sync_i  (sync2_q[i]),
      .db_o    (db_s[i]),
      .chg_o   (chg_s[i])
    );
  end

  // Register write decode; a clear and a simultaneous change event resolve to set.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    ien_d     = ien_q;
    evt_clr_s = 8'h00;
    out_wr_s  = 1'b0;
    if (bus_we) begin
      case (bus_addr)
        ADDR_OUT: begin out_d = bus_wd;          out_wr_s = 1'b1; end
        ADDR_SET: begin out_d = out_q | bus_wd;  out_wr_s = 1'b1; end
        ADDR_CLR: begin out_d = out_q & ~bus_wd; out_wr_s = 1'b1; end
        ADDR_TGL: begin out_d = out_q ^ bus_wd;  out_wr_s = 1'b1; end
        ADDR_DIR: dir_d = bus_wd;
        ADDR_EVT: evt_clr_s = bus_wd;
        ADDR_IEN: ien_d = bus_wd;
        default:  out_wr_s = 1'b0;
      endcase
    end else begin
      out_wr_s = 1'b0;
    end
    evt_d = (evt_q & ~evt_clr_s) | chg_s;
  end

  always_comb begin
    case (bus_addr)
      ADDR_OUT, ADDR_SET, ADDR_CLR, ADDR_TGL: rd_mux_s = out_q;
      ADDR_DIR: rd_mux_s = dir_q;
      ADDR_IN:  rd_mux_s = db_s;
      ADDR_EVT: rd_mux_s = evt_q;
      ADDR_IEN: rd_mux_s = ien_q;
      default:  rd_mux_s = 8'h00;
    endcase
  end

  // init_q forces one port_we pulse after reset so the pads load OUT = 0.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      out_q     <= 8'h00;
      dir_q     <= 8'h00;
      ien_q     <= 8'h00;
      evt_q     <= 8'h00;
      rd_q      <= 8'h00;
      irq_q     <= 1'b0;
      port_we_q <= 1'b0;
      init_q    <= 1'b0;
      sync1_q   <= 8'h00;
      sync2_q   <= 8'h00;
      presc_q   <= {PW{1'b0}};
      armed_q   <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      ien_q     <= ien_d;
      evt_q     <= evt_d;
      rd_q      <= bus_re ? rd_mux_s : rd_q;
      irq_q     <= |(evt_q & ien_q);
      port_we_q <= out_wr_s | ~init_q;
      init_q    <= 1'b1;
      sync1_q   <= port_rd;
      sync2_q   <= sync1_q;
      presc_q   <= tick_s ? {PW{1'b0}} : presc_q + PW'(1);
      armed_q   <= armed_q | tick_s;
    end
  end

  assign bus_rd   = rd_q;
  assign port_we  = port_we_q;
  assign port_wd  = out_q;
  assign port_dir = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ioport_ctrl.sv
// Directed self-checking bench for ioport_ctrl with DB_DIV = 4, DB_CNT = 2.
module tb_ioport_ctrl;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       bus_we = 1'b0;
  logic       bus_re = 1'b0;
  logic [2:0] bus_addr = 3'd0;
  logic [7:0] bus_wd = 8'h00;
  logic [7:0] port_rd = 8'h00;
  logic [7:0] bus_rd, port_wd, port_dir;
  logic       port_we, irq;

  int checks = 0;
  int failures = 0;
  int cyc;

  ioport_ctrl #(.DB_DIV(4), .DB_CNT(2)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_addr (bus_addr),
    .bus_wd   (bus_wd),
    .bus_rd   (bus_rd),
    .port_we  (port_we),
    .port_wd  (port_wd),
    .port_dir (port_dir),
    .port_rd  (port_rd),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Edges since reset release; debounce ticks land on edges where cyc % 4 == 0.
  always @(posedge clk or negedge resetq) begin
    if (!resetq) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wd = d;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    bus_re = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rd;
  endtask

  task automatic align_tick();
    do @(negedge clk); while (cyc % 4 != 0);
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_rd !== 8'h00) begin failures++; $display("FAIL reset_bus_rd got=%h exp=00", bus_rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (port_dir !== 8'h00) begin failures++; $display("FAIL reset_dir got=%h exp=00", port_dir); end
    checks++; if (port_wd !== 8'h00) begin failures++; $display("FAIL reset_wd got=%h exp=00", port_wd); end
    checks++; if (port_we !== 1'b0) begin failures++; $display("FAIL reset_we_low got=%b exp=0", port_we); end
    resetq = 1'b1;
    @(negedge clk);
    checks++; if (port_we !== 1'b1) begin failures++; $display("FAIL reset_we_pulse got=%b exp=1", port_we); end
    @(negedge clk);
    checks++; if (port_we !== 1'b0) begin failures++; $display("FAIL reset_we_end got=%b exp=0", port_we); end
  endtask

  task automatic test_out_ops();
    logic [2:0] a_tab [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [7:0] d_tab [4] = '{8'hA5, 8'h0F, 8'h81, 8'hFF};
    logic [7:0] e_tab [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
    logic [7:0] rd;
    for (int i = 0; i < 4; i++) begin
      bus_write(a_tab[i], d_tab[i]);
      checks++; if (port_wd !== e_tab[i]) begin failures++; $display("FAIL out_op%0d_wd got=%h exp=%h", i, port_wd, e_tab[i]); end
      checks++; if (port_we !== 1'b1) begin failures++; $display("FAIL out_op%0d_we got=%b exp=1", i, port_we); end
      @(negedge clk);
      checks++; if (port_we !== 1'b0) begin failures++; $display("FAIL out_op%0d_we_end got=%b exp=0", i, port_we); end
    end
    bus_read(3'd0, rd);
    checks++; if (rd !== 8'hD1) begin failures++; $display("FAIL read_out got=%h exp=D1", rd); end
    bus_read(3'd2, rd);
    checks++; if (rd !== 8'hD1) begin failures++; $display("FAIL read_set got=%h exp=D1", rd); end
    bus_write(3'd1, 8'h5A);
    checks++; if (port_dir !== 8'h5A) begin failures++; $display("FAIL dir_write got=%h exp=5A", port_dir); end
    checks++; if (port_we !== 1'b0) begin failures++; $display("FAIL dir_no_we got=%b exp=0", port_we); end
    bus_write(3'd5, 8'hFF);
    bus_read(3'd5, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL in_readonly got=%h exp=00", rd); end
    // Simultaneous read and write of OUT returns the pre-write value.
    bus_we = 1'b1; bus_re = 1'b1; bus_addr = 3'd0; bus_wd = 8'h11;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    checks++; if (bus_rd !== 8'hD1) begin failures++; $display("FAIL rw_same_rd got=%h exp=D1", bus_rd); end
    checks++; if (port_wd !== 8'h11) begin failures++; $display("FAIL rw_same_wd got=%h exp=11", port_wd); end
    @(negedge clk);
    checks++; if (bus_rd !== 8'hD1) begin failures++; $display("FAIL rd_hold got=%h exp=D1", bus_rd); end
  endtask

  task automatic test_glitch();
    logic [7:0] rd;
    port_rd = 8'h00;
    align_tick();
    port_rd = 8'h08;
    repeat (5) @(negedge clk);
    port_rd = 8'h00;
    repeat (12) @(negedge clk);
    bus_read(3'd5, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL glitch_in got=%h exp=00", rd); end
    bus_read(3'd6, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL glitch_evt got=%h exp=00", rd); end
  endtask

  task automatic test_debounce_irq();
    logic [7:0] rd;
    bus_write(3'd7, 8'h08);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
    align_tick();
    port_rd = 8'h08;
    repeat (8) @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
    bus_read(3'd5, rd);
    checks++; if (rd !== 8'h08) begin failures++; $display("FAIL db_in got=%h exp=08", rd); end
    bus_read(3'd6, rd);
    checks++; if (rd !== 8'h08) begin failures++; $display("FAIL db_evt got=%h exp=08", rd); end
  endtask

  task automatic test_evt_set_wins();
    logic [7:0] rd;
    align_tick();
    port_rd = 8'h00;
    repeat (7) @(negedge clk);
    bus_write(3'd6, 8'h08);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL setwin_irq got=%b exp=1", irq); end
    bus_read(3'd6, rd);
    checks++; if (rd !== 8'h08) begin failures++; $display("FAIL setwin_evt got=%h exp=08", rd); end
    bus_read(3'd5, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL setwin_in got=%h exp=00", rd); end
    bus_write(3'd6, 8'h08);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clr_irq_lag got=%b exp=1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq_fall got=%b exp=0", irq); end
    bus_read(3'd6, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL clr_evt got=%h exp=00", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    bus_write(3'd0, 8'h3C);
    checks++; if (port_wd !== 8'h3C) begin failures++; $display("FAIL mid_out got=%h exp=3C", port_wd); end
    port_rd = 8'hFF;
    align_tick();
    repeat (9) @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mid_irq_pre got=%b exp=1", irq); end
    port_rd = 8'h00;
    repeat (5) @(negedge clk);
    resetq = 1'b0;
    #1;
    checks++; if (port_wd !== 8'h00) begin failures++; $display("FAIL arst_wd got=%h exp=00", port_wd); end
    checks++; if (port_dir !== 8'h00) begin failures++; $display("FAIL arst_dir got=%h exp=00", port_dir); end
    checks++; if (bus_rd !== 8'h00) begin failures++; $display("FAIL arst_rd got=%h exp=00", bus_rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
    port_rd = 8'hFF;
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    checks++; if (port_we !== 1'b1) begin failures++; $display("FAIL arst_we_pulse got=%b exp=1", port_we); end
    bus_read(3'd5, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL pre_arm_in got=%h exp=00", rd); end
    repeat (10) @(negedge clk);
    bus_read(3'd6, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL arm_no_evt got=%h exp=00", rd); end
    bus_read(3'd5, rd);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL arm_in got=%h exp=FF", rd); end
    bus_read(3'd0, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL arst_out got=%h exp=00", rd); end
  endtask

  initial begin
    test_reset();
    test_out_ops();
    test_glitch();
    test_debounce_irq();
    test_evt_set_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
